// File: rtl/uart_input_buffer_pkg.sv
// Shared types and constants for the UART input byte buffer.
package uart_input_buffer_pkg;

    localparam int UART_WORD_BYTES = 4;

    typedef logic [7:0]  uart_byte_t;
    typedef logic [31:0] word_t;

    // The first-received byte lands in the most significant position.
    function automatic word_t pack_word(input uart_byte_t b0, input uart_byte_t b1,
                                        input uart_byte_t b2, input uart_byte_t b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/uart_byte_fifo_ram.sv
// Byte storage for the UART input buffer: one synchronous write port and
// four asynchronous read ports so a whole word can be read in one cycle.
module uart_byte_fifo_ram
    import uart_input_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr [UART_WORD_BYTES],
    output logic [7:0]            rd_data [UART_WORD_BYTES]
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < UART_WORD_BYTES; i++) begin
            rd_data[i] = mem[rd_addr[i]];
        end
    end

endmodule

// File: rtl/uart_input_buffer.sv
// Byte FIFO between UART RX and the read-instruction consumer; presents words or bytes.
// Optional feature: define UART_INPUT_DROP_COUNT_EN to add a saturating drop_count output.
module uart_input_buffer
    import uart_input_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  byte_mode,
    input  logic                  input_take,
    output logic                  input_ready,
    output logic [31:0]           input_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
`ifdef UART_INPUT_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] WORD_C = (DEPTH_LOG2 + 1)'(UART_WORD_BYTES);
    localparam logic [DEPTH_LOG2:0] ONE_C  = (DEPTH_LOG2 + 1)'(1);

    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  push;
    logic                  drop;
    logic [DEPTH_LOG2:0]   pop_amount;
    logic [DEPTH_LOG2-1:0] rd_addr [UART_WORD_BYTES];
    uart_byte_t            rd_data [UART_WORD_BYTES];

    uart_byte_fifo_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data(rx_byte),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    // Full check uses the pre-pop count, so a full FIFO drops even when popping.
    always_comb begin
        push        = rx_valid && (count < FULL_C);
        drop        = rx_valid && !push;
        input_ready = byte_mode ? (count != '0) : (count >= WORD_C);
        pop_amount  = '0;
        if (input_take && input_ready) begin
            pop_amount = byte_mode ? ONE_C : WORD_C;
        end
    end

    always_comb begin
        for (int i = 0; i < UART_WORD_BYTES; i++) begin
            rd_addr[i] = rd_ptr + DEPTH_LOG2'(i);
        end
        input_data = '0;
        if (input_ready) begin
            input_data = byte_mode ? {24'b0, rd_data[0]}
                                   : pack_word(rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr <= rd_ptr + pop_amount[DEPTH_LOG2-1:0];
            count  <= count + {{DEPTH_LOG2{1'b0}}, push} - pop_amount;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_INPUT_DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
